alu_sequencer: RTL and testbench

Multi-cycle fixed-point arithmetic engine that executes the calculator's four operations (+, −, ×, ÷) on signed two-decimal fixed-point operands (value × 100). It uses a start/done handshake and one iterative shift-add multiplier plus restoring divider instead of single-cycle combinational multiply and divide. It sits between the keypad control FSM and the display path: the control FSM issues one operation on `=`, waits for `done`, then loads `result` back as the first operand.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/seq_divider.sv | 62 ++++++
 rtl/alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU op encoding, fixed-point scale and
// the sequencer state encoding.
package calc_pkg;

  // Fixed-point values are stored as value x 100 (two decimal places).
  localparam int FIXED_POINT_MULTIPLIER = 100;

  // Same encoding as the keypad control FSM's ALU-op register.
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } calc_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU,
    S_MUL,
    S_DIVIDE,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Start/done request bus between the control FSM (master) and the
// arithmetic sequencer (slave).
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, result, overflow, div_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, result, overflow, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, MSB first. The dividend register doubles as
// the quotient register: each iteration shifts a dividend bit out of the top
// and the new quotient bit in at the bottom.
// valid is high during the cycle of the final iteration and quotient shows
// the value that iteration produces, so the consumer captures the finished
// quotient on the same edge the divider completes.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] quotient
);
  localparam int CW = $clog2(2*WIDTH + 1);

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dsr_q;
  logic [WIDTH-1:0]   rem_lo;
  logic [WIDTH-1:0]   rem_next;
  logic               fits;

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  // The true remainder always stays below the divisor, so the low WIDTH bits
  // of the shifted value and of the difference are exact.
  always_comb begin
    fits     = ({rem_q, dvd_q[2*WIDTH-1]} >= {1'b0, dsr_q});
    rem_lo   = {rem_q[WIDTH-2:0], dvd_q[2*WIDTH-1]};
    rem_next = fits ? (rem_lo - dsr_q) : rem_lo;
    quotient = {dvd_q[2*WIDTH-2:0], fits};
  end

  assign busy  = (cnt_q != '0);
  assign valid = (cnt_q == CW'(1));

  // Load a new division or advance the running one by one bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(2*WIDTH);
      dvd_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
      dvd_q <= quotient;
      rem_q <= rem_next;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle signed fixed-point (value x SCALE) add/sub/mul/div engine.
// Multiply is shift-add on magnitudes followed by a divide by SCALE; divide
// is |a|*SCALE / |b|. Both share one seq_divider; sign is applied to the
// truncated magnitude and results are clamped to +/-(2^(WIDTH-1)-1).
//
// state    | meaning
// S_IDLE   | waiting for start; operands latched on acceptance
// S_ALU    | add/sub finish here; mul/div set up their iterations
// S_MUL    | WIDTH shift-add iterations on the magnitudes
// S_DIVIDE | 2*WIDTH divider iterations, then sign and saturate
// S_DONE   | done pulse, result and flags valid
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SCALE = FIXED_POINT_MULTIPLIER
) (
  input logic            clock,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);
  localparam int                      MCW          = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]        MAX_MAG      = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]   SUM_MAX      = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]   SUM_MIN      = -SUM_MAX;
  localparam logic [2*WIDTH-1:0]      SCALE_WIDE   = (2*WIDTH)'(SCALE);
  localparam logic [WIDTH-1:0]        SCALE_NARROW = WIDTH'(SCALE);

  seq_state_e state_q, state_d;
  calc_op_e   op_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q, abs_a, abs_b;
  logic               sign_a_q, sign_b_q;
  logic [2*WIDTH-1:0] product_q, mcand_q, product_next;
  logic [MCW-1:0]     mul_cnt_q;
  logic               mul_last;
  logic [WIDTH-1:0]   result_q;
  logic               overflow_q, div_zero_q;

  logic signed [WIDTH:0] a_ext, b_ext, sum;
  logic [WIDTH-1:0]      as_res, q_mag, q_res;
  logic                  as_ovf, q_ovf;

  logic               div_load, div_busy, div_valid;
  logic [2*WIDTH-1:0] div_dividend, div_quotient;
  logic [WIDTH-1:0]   div_divisor;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (div_quotient)
  );

  assign abs_a        = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign abs_b        = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
  assign product_next = product_q + (mag_b_q[0] ? mcand_q : '0);
  assign mul_last     = (mul_cnt_q == MCW'(1));

  // Signed WIDTH+1-bit add/sub rebuilt from sign and magnitude, then clamped.
  always_comb begin
    a_ext = {1'b0, mag_a_q};
    b_ext = {1'b0, mag_b_q};
    if (sign_a_q) a_ext = -a_ext;
    if (sign_b_q) b_ext = -b_ext;
    sum    = (op_q == SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    as_res = sum[WIDTH-1:0];
    as_ovf = 1'b0;
    if (sum > SUM_MAX) begin
      as_res = MAX_MAG;
      as_ovf = 1'b1;
    end else if (sum < SUM_MIN) begin
      as_res = -MAX_MAG;
      as_ovf = 1'b1;
    end
  end

  // Clamp the final quotient magnitude, then apply the mul/div sign.
  always_comb begin
    q_mag = div_quotient[WIDTH-1:0];
    q_ovf = 1'b0;
    if (div_quotient > {{WIDTH{1'b0}}, MAX_MAG}) begin
      q_mag = MAX_MAG;
      q_ovf = 1'b1;
    end
    q_res = (sign_a_q ^ sign_b_q) ? -q_mag : q_mag;
  end

  // Divider feed: |a|*SCALE by |b| for div, finished product by SCALE for mul.
  always_comb begin
    div_load     = 1'b0;
    div_dividend = product_next;
    div_divisor  = SCALE_NARROW;
    if (state_q == S_ALU) begin
      div_load     = (op_q == DIV) && (mag_b_q != '0);
      div_dividend = {{WIDTH{1'b0}}, mag_a_q} * SCALE_WIDE;
      div_divisor  = mag_b_q;
    end else if (state_q == S_MUL) begin
      div_load     = mul_last;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; start is only looked at in S_IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_ALU;
      S_ALU: begin
        if (op_q == MUL)                         state_d = S_MUL;
        else if (op_q == DIV && mag_b_q != '0)   state_d = S_DIVIDE;
        else                                     state_d = S_DONE;
      end
      S_MUL:    if (mul_last) state_d = S_DIVIDE;
      // An idle divider here can only mean lost state; bail out rather than hang.
      S_DIVIDE: if (div_valid) state_d = S_DONE;
                else if (!div_busy) state_d = S_IDLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand capture, multiply iterations and result/flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= ADD;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      product_q  <= '0;
      mcand_q    <= '0;
      mul_cnt_q  <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          op_q       <= calc_op_e'(bus.op);
          mag_a_q    <= abs_a;
          mag_b_q    <= abs_b;
          sign_a_q   <= bus.operand_a[WIDTH-1];
          sign_b_q   <= bus.operand_b[WIDTH-1];
          overflow_q <= 1'b0;
          div_zero_q <= 1'b0;
        end
        S_ALU: begin
          if (op_q == ADD || op_q == SUB) begin
            result_q   <= as_res;
            overflow_q <= as_ovf;
          end else if (op_q == MUL) begin
            product_q <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, mag_a_q};
            mul_cnt_q <= MCW'(WIDTH);
          end else if (mag_b_q == '0) begin
            result_q   <= '0;
            div_zero_q <= 1'b1;
          end
        end
        S_MUL: begin
          product_q <= product_next;
          mcand_q   <= mcand_q << 1;
          mag_b_q   <= mag_b_q >> 1;
          mul_cnt_q <= mul_cnt_q - MCW'(1);
        end
        S_DIVIDE: if (div_valid) begin
          result_q   <= q_res;
          overflow_q <= q_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table of single operations with
// hand-computed results, then hand-written busy-rejection and reset-abort
// sequences.
module tb_alu_sequencer;
  import calc_pkg::*;

  localparam int W = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W), .SCALE(100)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [1:0] op;
    int         a;
    int         b;
    int         exp_res;
    bit         exp_ovf;
    bit         exp_dz;
    int         exp_lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, and follow it
  // until busy drops, sampling 1 ns after each rising edge.
  task automatic run_op(input logic [1:0] op, input int a, input int b,
                        output int res, output bit ovf, output bit dz,
                        output int lat, output int busy_cyc,
                        output int done_cnt, output bit finished);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.op        = 2'($urandom_range(0, 3));
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    res = 0; ovf = 1'b0; dz = 1'b0;
    lat = -1; busy_cyc = 0; done_cnt = 0; finished = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          res = int'(bus.result);
          ovf = bus.overflow;
          dz  = bus.div_zero;
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  res, lat, busy_cyc, done_cnt, rej_res, rej_lat;
    bit  ovf, dz, finished;

    vecs[0]  = '{"mul_12.34x2.00",   MUL, 1234,         200,   2468,        1'b0, 1'b0, 97};
    vecs[1]  = '{"div_-7.50/2.50",   DIV, -750,         250,   -300,        1'b0, 1'b0, 65};
    vecs[2]  = '{"div_trunc",        DIV, 100,          300,   33,          1'b0, 1'b0, 65};
    vecs[3]  = '{"div_by_zero",      DIV, 500,          0,     0,           1'b0, 1'b1, 1};
    vecs[4]  = '{"add_sat_pos",      ADD, 2147483000,   1000,  2147483647,  1'b1, 1'b0, 1};
    vecs[5]  = '{"sub_sat_neg",      SUB, -2147483000,  1000,  -2147483647, 1'b1, 1'b0, 1};
    vecs[6]  = '{"add_mixed",        ADD, 150,          -275,  -125,        1'b0, 1'b0, 1};
    vecs[7]  = '{"sub_neg_result",   SUB, 500,          1250,  -750,        1'b0, 1'b0, 1};
    vecs[8]  = '{"mul_neg",          MUL, -150,         250,   -375,        1'b0, 1'b0, 97};
    vecs[9]  = '{"mul_min_sat",      MUL, 32'sh8000_0000, 100, -2147483647, 1'b1, 1'b0, 97};
    vecs[10] = '{"div_large",        DIV, 100000,       1,     10000000,    1'b0, 1'b0, 65};
    vecs[11] = '{"div_sat",          DIV, 2147483647,   1,     2147483647,  1'b1, 1'b0, 65};
    vecs[12] = '{"mul_neg_neg",      MUL, -333,         -3,    9,           1'b0, 1'b0, 97};
    vecs[13] = '{"add_min_clamp",    ADD, 32'sh8000_0000, 0,   -2147483647, 1'b1, 1'b0, 1};
    vecs[14] = '{"mul_underflow0",   MUL, 7,            3,     0,           1'b0, 1'b0, 97};
    vecs[15] = '{"div_neg_to_zero",  DIV, -1,           300,   0,           1'b0, 1'b0, 65};
    vecs[16] = '{"add_exact_max",    ADD, 2147483000,   647,   2147483647,  1'b0, 1'b0, 1};

    bus.start     = 1'b0;
    bus.op        = 2'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    #3;
    check("reset/busy",     bus.busy,     0);
    check("reset/done",     bus.done,     0);
    check("reset/result",   bus.result,   0);
    check("reset/overflow", bus.overflow, 0);
    check("reset/div_zero", bus.div_zero, 0);

    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, ovf, dz, lat, busy_cyc, done_cnt, finished);
      check({vecs[i].name, "/finished"},   finished, 1);
      check({vecs[i].name, "/result"},     res,      vecs[i].exp_res);
      check({vecs[i].name, "/overflow"},   ovf,      vecs[i].exp_ovf);
      check({vecs[i].name, "/div_zero"},   dz,       vecs[i].exp_dz);
      check({vecs[i].name, "/latency"},    lat,      vecs[i].exp_lat);
      check({vecs[i].name, "/busy_cyc"},   busy_cyc, vecs[i].exp_lat + 1);
      check({vecs[i].name, "/done_count"}, done_cnt, 1);
      check({vecs[i].name, "/held"},       $signed(bus.result), vecs[i].exp_res);
    end

    // Busy rejection: an add pulsed mid-multiply and another pulsed in DONE.
    @(negedge clock);
    bus.start = 1'b1; bus.op = MUL; bus.operand_a = 1234; bus.operand_b = 200;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    done_cnt = 0; rej_res = 0; rej_lat = -1;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clock);
      #1;
      if (k == 9) begin
        bus.start = 1'b1; bus.op = ADD; bus.operand_a = 1; bus.operand_b = 1;
      end else if (k == 10) begin
        bus.start = 1'b0;
      end
      if (rej_lat > 0 && k == rej_lat + 1) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        if (rej_lat < 0) begin
          rej_lat = k;
          rej_res = int'(bus.result);
        end
        bus.start = 1'b1; bus.op = ADD; bus.operand_a = 1; bus.operand_b = 1;
      end
    end
    bus.start = 1'b0;
    check("reject/done_count", done_cnt, 1);
    check("reject/latency",    rej_lat,  97);
    check("reject/result",     rej_res,  2468);
    check("reject/busy_end",   bus.busy, 0);
    check("reject/held",       $signed(bus.result), 2468);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clock);
    bus.start = 1'b1; bus.op = MUL; bus.operand_a = 1234; bus.operand_b = 200;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    check("midreset/busy_before", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("midreset/busy",     bus.busy,     0);
    check("midreset/done",     bus.done,     0);
    check("midreset/result",   bus.result,   0);
    check("midreset/overflow", bus.overflow, 0);
    repeat (2) @(negedge clock);
    check("midreset/no_done",  bus.done,     0);
    reset_n = 1'b1;
    run_op(ADD, 150, -275, res, ovf, dz, lat, busy_cyc, done_cnt, finished);
    check("after_reset/finished", finished, 1);
    check("after_reset/result",   res,      -125);
    check("after_reset/overflow", ovf,      0);
    check("after_reset/latency",  lat,      1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
